if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined processor. It owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that feeds the ID stage's opcode decode and control logic. It handles load-use stalls, branch/jump redirects from later stages, and HALT detection. After a HALT is fetched, it stops fetching and emits bubbles.

---
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 tb/tb_if_fetch_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 16-bit pipelined processor. It owns the
// program counter, presents it to instruction memory, and registers the
// fetched word into the IF/ID pipeline register. It also handles load-use
// stalls, redirects from later stages and HALT detection. Once a HALT word
// has been fetched, the stage stops fetching and emits bubbles until a
// redirect or reset arrives.
//
// Ports:
//   Clk               rising-edge clock
//   Rst_n             synchronous, active-low reset
//   Stall             hold PC, IF/ID and state this cycle
//   Redirect          taken branch/jump from a later stage
//   Redirect_PC       redirect target
//   Imem_Addr         instruction-memory address (the PC register itself)
//   Imem_Data         instruction word, combinational read of Imem_Addr
//   IFID_Instruction  registered instruction handed to ID
//   IFID_PC_Plus1     registered PC+1 of that instruction
//   IFID_Valid        1 = real instruction, 0 = bubble
//   Halted            fetch state machine is in HALTED
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int unsigned     PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [15:0]     NOP_WORD = 16'h1000
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Stall,
   input  logic            Redirect,
   input  logic [PC_W-1:0] Redirect_PC,
   output logic [PC_W-1:0] Imem_Addr,
   input  logic [15:0]     Imem_Data,
   output logic [15:0]     IFID_Instruction,
   output logic [PC_W-1:0] IFID_PC_Plus1,
   output logic            IFID_Valid,
   output logic            Halted
);

   typedef enum logic {
      ST_FETCH  = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     instr_q, instr_d;
   logic [PC_W-1:0] pc_plus1_q, pc_plus1_d;
   logic            valid_q, valid_d;
   logic            halted_q, halted_d;

   logic [PC_W-1:0] pc_inc;
   logic            fetched_halt;

   // PC+1 naturally wraps modulo 2^PC_W. Any word whose top nibble is zero
   // is a HALT, not just 16'h0000.
   assign pc_inc       = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
   assign fetched_halt = (Imem_Data[15:12] == 4'b0000);

   // Next-state logic. Redirect beats Stall so a wrong-path HALT or a stalled
   // wrong-path instruction can always be squashed. A bubble keeps the old
   // PC_Plus1 because ID ignores it whenever Valid is low.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;

      if (Redirect) begin
         pc_d    = Redirect_PC;
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         state_d = ST_FETCH;
      end else if (!Stall) begin
         case (state_q)
            ST_FETCH: begin
               instr_d    = Imem_Data;
               pc_plus1_d = pc_inc;
               valid_d    = 1'b1;
               if (fetched_halt) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d = pc_inc;
               end
            end
            ST_HALTED: begin
               instr_d = NOP_WORD;
               valid_d = 1'b0;
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end

      halted_d = (state_d == ST_HALTED);
   end

   // All stage state lives here. Reset is synchronous and wins over
   // everything else sampled on the same edge.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_WORD;
         pc_plus1_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus1_q <= pc_plus1_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   assign Imem_Addr        = pc_q;
   assign IFID_Instruction = instr_q;
   assign IFID_PC_Plus1    = pc_plus1_q;
   assign IFID_Valid       = valid_q;
   assign Halted           = halted_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. A 64K-word memory array models the
// combinational instruction memory. Each scenario task drives inputs just
// after a rising edge and checks the DUT outputs #1 after the next edge.
// Observed outputs are packed as {Imem_Addr, IFID_Instruction,
// IFID_PC_Plus1, IFID_Valid, Halted}.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   logic        Clk;
   logic        Rst_n;
   logic        Stall;
   logic        Redirect;
   logic [15:0] Redirect_PC;
   logic [15:0] Imem_Addr;
   logic [15:0] Imem_Data;
   logic [15:0] IFID_Instruction;
   logic [15:0] IFID_PC_Plus1;
   logic        IFID_Valid;
   logic        Halted;

   logic [15:0] mem [0:65535];

   int n_compared;
   int n_mismatched;

   logic [49:0] obs;
   logic [49:0] exp_v;

   if_fetch_stage #(
      .PC_W    (16),
      .RESET_PC(16'h0000),
      .NOP_WORD(16'h1000)
   ) dut (
      .Clk             (Clk),
      .Rst_n           (Rst_n),
      .Stall           (Stall),
      .Redirect        (Redirect),
      .Redirect_PC     (Redirect_PC),
      .Imem_Addr       (Imem_Addr),
      .Imem_Data       (Imem_Data),
      .IFID_Instruction(IFID_Instruction),
      .IFID_PC_Plus1   (IFID_PC_Plus1),
      .IFID_Valid      (IFID_Valid),
      .Halted          (Halted)
   );

   // Combinational instruction memory read.
   assign Imem_Data = mem[Imem_Addr];

   // Free-running 10-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 16'h0000;
      tick();
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0000, 16'h1000, 16'h0000, 1'b0, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL reset_state: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_sequential();
      Rst_n = 1'b1;
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0001, 16'h1001, 16'h0001, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL seq_edge1: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0002, 16'h2002, 16'h0002, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL seq_edge2: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_stall();
      Stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
         exp_v = {16'h0002, 16'h2002, 16'h0002, 1'b1, 1'b0};
         n_compared++;
         if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL stall_hold%0d: got %h want %h", i, obs, exp_v); end
      end
      Stall = 1'b0;
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0003, 16'h3003, 16'h0003, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL stall_release: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_redirect_over_stall();
      Redirect = 1'b1; Redirect_PC = 16'h0040; Stall = 1'b1;
      tick();
      Redirect = 1'b0; Stall = 1'b0;
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0040, 16'h1000, 16'h0003, 1'b0, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL redirect_bubble: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0041, 16'h4A4A, 16'h0041, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL redirect_target: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_halt();
      Redirect = 1'b1; Redirect_PC = 16'h0005;
      tick();
      Redirect = 1'b0;
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0005, 16'h1000, 16'h0041, 1'b0, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_redirect: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0005, 16'h0000, 16'h0006, 1'b1, 1'b1};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_capture: got %h want %h", obs, exp_v); end
      for (int i = 0; i < 2; i++) begin
         tick();
         obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
         exp_v = {16'h0005, 16'h1000, 16'h0006, 1'b0, 1'b1};
         n_compared++;
         if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_bubble%0d: got %h want %h", i, obs, exp_v); end
      end
      Stall = 1'b1;
      tick();
      Stall = 1'b0;
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0005, 16'h1000, 16'h0006, 1'b0, 1'b1};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_stalled: got %h want %h", obs, exp_v); end
      Redirect = 1'b1; Redirect_PC = 16'h0010;
      tick();
      Redirect = 1'b0;
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0010, 16'h1000, 16'h0006, 1'b0, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_cleared: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0011, 16'h6161, 16'h0011, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_resume: got %h want %h", obs, exp_v); end
      // 0x0ABC has a zero opcode nibble and must halt too.
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0011, 16'h0ABC, 16'h0012, 1'b1, 1'b1};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL halt_nibble: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_pc_wrap();
      Redirect = 1'b1; Redirect_PC = 16'hFFFF;
      tick();
      Redirect = 1'b0;
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'hFFFF, 16'h1000, 16'h0012, 1'b0, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL wrap_redirect: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL wrap_fetch: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0001, 16'h1001, 16'h0001, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL wrap_next: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_reset_mid();
      Redirect = 1'b1; Redirect_PC = 16'h0005;
      tick();
      Redirect = 1'b0;
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0005, 16'h0000, 16'h0006, 1'b1, 1'b1};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rmid_halted: got %h want %h", obs, exp_v); end
      Rst_n = 1'b0; Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 16'h0077;
      tick();
      Rst_n = 1'b1; Stall = 1'b0; Redirect = 1'b0;
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0000, 16'h1000, 16'h0000, 1'b0, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rmid_reset: got %h want %h", obs, exp_v); end
      tick();
      obs   = {Imem_Addr, IFID_Instruction, IFID_PC_Plus1, IFID_Valid, Halted};
      exp_v = {16'h0001, 16'h1001, 16'h0001, 1'b1, 1'b0};
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rmid_restart: got %h want %h", obs, exp_v); end
   endtask

   // Load the program image, then run every scenario in order.
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h1000;
      mem[16'h0000] = 16'h1001;
      mem[16'h0001] = 16'h2002;
      mem[16'h0002] = 16'h3003;
      mem[16'h0005] = 16'h0000;
      mem[16'h0010] = 16'h6161;
      mem[16'h0011] = 16'h0ABC;
      mem[16'h0040] = 16'h4A4A;
      mem[16'h0041] = 16'h5B5B;
      mem[16'hFFFF] = 16'h1234;

      test_reset();
      test_sequential();
      test_stall();
      test_redirect_over_stall();
      test_halt();
      test_pc_wrap();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
